// File: rtl/nios_core_cpu_mul_sequencer_if.sv
// Command, multiplier-cell and response signals between CPU execute and the 16x16 cell.
// master = sequencer side, slave = CPU execute / cell side.
interface nios_core_cpu_mul_sequencer_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_src1;
    logic [31:0]      cmd_src2;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      mul_src1;
    logic [31:0]      mul_src2;
    logic             mul_en;
    logic [31:0]      cell_p1;
    logic [31:0]      cell_p2;
    logic [31:0]      cell_p3;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_tag,
        input  cell_p1, cell_p2, cell_p3, rsp_ready,
        output cmd_ready, mul_src1, mul_src2, mul_en,
        output rsp_valid, rsp_result, rsp_tag
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_tag,
        output cell_p1, cell_p2, cell_p3, rsp_ready,
        input  cmd_ready, mul_src1, mul_src2, mul_en,
        input  rsp_valid, rsp_result, rsp_tag
    );
endinterface

// File: rtl/nios_core_cpu_mul_sequencer.sv
// Multiply sequencer: drives the 16x16 cell for three partial products, forms hi*hi serially,
// and assembles MUL / MULXUU / MULXSU / MULXSS results with signed high-word corrections.
module nios_core_cpu_mul_sequencer #(
    parameter int CELL_LAT = 1,
    parameter int TAG_W    = 4
) (
    input  logic clk,
    input  logic reset,
    nios_core_cpu_mul_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CELL = 3'd1,
        SUM  = 3'd2,
        HIHI = 3'd3,
        FIX  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [3:0] CELL_LAST = 4'(CELL_LAT - 1);

    state_t           state_r;
    logic [3:0]       step_r;
    logic [1:0]       op_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [TAG_W-1:0] tag_r;
    logic [31:0]      p1_r;
    logic [32:0]      mid_r;
    logic [31:0]      acc_hi_r;
    logic [31:0]      p4_r;
    logic             cmd_ready_r;
    logic             mul_en_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_result_r;

    logic [63:0]      acc64_s;
    logic [15:0]      hb_s;
    logic [31:0]      h_add_s;
    logic [31:0]      corr_a_s;
    logic [31:0]      corr_b_s;
    logic [31:0]      hi_s;

    // Partial-product assembly, serial hi*hi addend and signed high-word corrections.
    always_comb begin
        acc64_s = {32'h0000_0000, p1_r} + ({31'h0000_0000, mid_r} << 16);
        hb_s    = b_r[31:16];
        if (hb_s[step_r]) begin
            h_add_s = {16'h0000, a_r[31:16]} << step_r;
        end else begin
            h_add_s = 32'h0000_0000;
        end
        if (op_r[1] && a_r[31]) begin
            corr_a_s = b_r;
        end else begin
            corr_a_s = 32'h0000_0000;
        end
        if ((op_r == 2'b11) && b_r[31]) begin
            corr_b_s = a_r;
        end else begin
            corr_b_s = 32'h0000_0000;
        end
        hi_s = acc_hi_r + p4_r - corr_a_s - corr_b_s;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            step_r       <= 4'd0;
            op_r         <= 2'b00;
            a_r          <= 32'h0000_0000;
            b_r          <= 32'h0000_0000;
            tag_r        <= '0;
            p1_r         <= 32'h0000_0000;
            mid_r        <= 33'h0_0000_0000;
            acc_hi_r     <= 32'h0000_0000;
            p4_r         <= 32'h0000_0000;
            cmd_ready_r  <= 1'b1;
            mul_en_r     <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_r        <= bus.cmd_op;
                        a_r         <= bus.cmd_src1;
                        b_r         <= bus.cmd_src2;
                        tag_r       <= bus.cmd_tag;
                        step_r      <= 4'd0;
                        cmd_ready_r <= 1'b0;
                        mul_en_r    <= 1'b1;
                        state_r     <= CELL;
                    end
                end
                CELL: begin
                    if (step_r == CELL_LAST) begin
                        mul_en_r <= 1'b0;
                        step_r   <= 4'd0;
                        state_r  <= SUM;
                    end else begin
                        step_r <= step_r + 4'd1;
                    end
                end
                // Phase 0 samples the cell; phase 1 uses the registered products.
                SUM: begin
                    if (step_r == 4'd0) begin
                        p1_r   <= bus.cell_p1;
                        mid_r  <= {1'b0, bus.cell_p2} + {1'b0, bus.cell_p3};
                        step_r <= 4'd1;
                    end else begin
                        step_r <= 4'd0;
                        if (op_r == 2'b00) begin
                            rsp_result_r <= acc64_s[31:0];
                            rsp_valid_r  <= 1'b1;
                            state_r      <= DONE;
                        end else begin
                            acc_hi_r <= acc64_s[63:32];
                            p4_r     <= 32'h0000_0000;
                            state_r  <= HIHI;
                        end
                    end
                end
                HIHI: begin
                    p4_r <= p4_r + h_add_s;
                    if (step_r == 4'd15) begin
                        step_r  <= 4'd0;
                        state_r <= FIX;
                    end else begin
                        step_r <= step_r + 4'd1;
                    end
                end
                FIX: begin
                    rsp_result_r <= hi_s;
                    rsp_valid_r  <= 1'b1;
                    state_r      <= DONE;
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    step_r      <= 4'd0;
                    cmd_ready_r <= 1'b1;
                    mul_en_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.mul_src1   = a_r;
    assign bus.mul_src2   = b_r;
    assign bus.mul_en     = mul_en_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_tag    = tag_r;
endmodule

// File: tb/tb_nios_core_cpu_mul_sequencer.sv
// Directed bench for the multiply sequencer with a one-cycle registered cell model.
module tb_nios_core_cpu_mul_sequencer;
    logic clk;
    logic reset;
    int   checks_total;
    int   checks_passed;

    nios_core_cpu_mul_sequencer_if #(.TAG_W(4)) bus ();

    nios_core_cpu_mul_sequencer #(.CELL_LAT(1), .TAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 16x16 cell: products registered one cycle after mul_en.
    always_ff @(posedge clk) begin
        if (bus.mul_en) begin
            bus.cell_p1 <= {16'h0000, bus.mul_src1[15:0]}  * {16'h0000, bus.mul_src2[15:0]};
            bus.cell_p2 <= {16'h0000, bus.mul_src1[15:0]}  * {16'h0000, bus.mul_src2[31:16]};
            bus.cell_p3 <= {16'h0000, bus.mul_src1[31:16]} * {16'h0000, bus.mul_src2[15:0]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total = checks_total + 1;
        if (obs === exp) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input int hold,
                         output logic [31:0] res, output logic [3:0] rtag,
                         output int lat, output int en_cnt);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_src1  = a;
        bus.cmd_src2  = b;
        bus.cmd_tag   = tag;
        bus.rsp_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        lat    = 0;
        en_cnt = 0;
        while (!bus.rsp_valid && lat < 100) begin
            if (bus.mul_en) begin
                en_cnt = en_cnt + 1;
                check("mul_src1", bus.mul_src1, a);
                check("mul_src2", bus.mul_src2, b);
            end
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        if (lat >= 100) begin
            check("rsp_timeout", 32'(lat), 32'd0);
        end
        res  = bus.rsp_result;
        rtag = bus.rsp_tag;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_result", bus.rsp_result, res);
            check("hold_tag", 32'(bus.rsp_tag), 32'(tag));
            check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        logic [3:0]  rtag;
        int          lat;
        int          en_cnt;
        int          stray;

        checks_total  = 0;
        checks_passed = 0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_src1  = 32'h0000_0000;
        bus.cmd_src2  = 32'h0000_0000;
        bus.cmd_tag   = 4'h0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_mul_en", 32'(bus.mul_en), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'h0000_0000);
        check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        check("rst_mul_src1", bus.mul_src1, 32'h0000_0000);

        do_op(2'b00, 32'h0001_0003, 32'h0002_0005, 4'h3, 0, res, rtag, lat, en_cnt);
        check("mul_result", res, 32'h000B_000F);
        check("mul_latency", 32'(lat), 32'd3);
        check("mul_tag", 32'(rtag), 32'h3);
        check("mul_en_cycles", 32'(en_cnt), 32'd1);

        do_op(2'b01, 32'h0001_0003, 32'h0002_0005, 4'h5, 0, res, rtag, lat, en_cnt);
        check("mulxuu_result", res, 32'h0000_0002);
        check("mulxuu_latency", 32'(lat), 32'd20);
        check("mulxuu_en_cycles", 32'(en_cnt), 32'd1);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h1, 0, res, rtag, lat, en_cnt);
        check("mulxuu_ones", res, 32'hFFFF_FFFE);

        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2, 0, res, rtag, lat, en_cnt);
        check("mulxss_ones", res, 32'h0000_0000);

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h4, 0, res, rtag, lat, en_cnt);
        check("mul_ones", res, 32'h0000_0001);

        do_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 4'hA, 0, res, rtag, lat, en_cnt);
        check("mulxsu_result", res, 32'hFFFF_FFFF);
        check("mulxsu_tag", 32'(rtag), 32'hA);

        do_op(2'b11, 32'h8000_0000, 32'h0000_0003, 4'h6, 0, res, rtag, lat, en_cnt);
        check("mulxss_neg", res, 32'hFFFF_FFFE);

        do_op(2'b00, 32'h0000_1234, 32'h0000_0010, 4'h7, 5, res, rtag, lat, en_cnt);
        check("bp_result", res, 32'h0001_2340);
        check("bp_tag", 32'(rtag), 32'h7);

        // Abort in the middle of the serial hi*hi phase.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_src1  = 32'h1234_5678;
        bus.cmd_src2  = 32'h9ABC_DEF0;
        bus.cmd_tag   = 4'h9;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_mul_en", 32'(bus.mul_en), 32'd0);
        check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) stray = stray + 1;
        end
        check("abort_no_rsp", 32'(stray), 32'd0);

        do_op(2'b00, 32'h0000_0007, 32'h0000_0006, 4'hC, 0, res, rtag, lat, en_cnt);
        check("post_abort_result", res, 32'h0000_002A);
        check("post_abort_tag", 32'(rtag), 32'hC);
        check("post_abort_latency", 32'(lat), 32'd3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
